ram_burst_arbiter: RTL and testbench

- Sequences and shares the 64-bit byte-addressed burst RAM (8 bytes per beat, shared bidirectional data bus) between one write requester and one read requester.
- The RAM's burst protocol is:
  - hold the enable high and the start address constant; the RAM auto-increments 8 bytes per cycle internally;
  - drop the enable for at least one cycle before the next burst.
- Latches burst commands, arbitrates round-robin on contention, generates the RAM enables/addresses, drives or releases the data bus, and reports beat/done status back to each requester.

---
 rtl/ram_burst_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_burst_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_arbiter
// Brief    : Round-robin sharing of a burst RAM between one writer and one
//            reader; sequences enables/addresses and the shared data bus.
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_arbiter #(
    parameter int ADDR_W = 30,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    output logic              wr_ack,
    input  logic [63:0]       wr_data,
    output logic              wr_data_pop,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_ack,
    output logic [63:0]       rd_data,
    output logic              rd_data_vld,
    output logic              rd_done,
    output logic              busy,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    inout  wire  [63:0]       ram_data
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WR_BURST = 2'd1;
    localparam logic [1:0] c_RD_BURST = 2'd2;

    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~(ADDR_W'(7));

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_beat_cnt;
    logic             r_last_grant_rd;
    logic             w_grant_wr;
    logic             w_grant_rd;

    // On contention the side that did not win last time is served.
    assign w_grant_wr = wr_req && (!rd_req || r_last_grant_rd);
    assign w_grant_rd = rd_req && (!wr_req || !r_last_grant_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_IDLE;
            r_len           <= '0;
            r_beat_cnt      <= '0;
            r_last_grant_rd <= 1'b1;
            ram_wr_en       <= 1'b0;
            ram_rd_en       <= 1'b0;
            ram_wr_addr     <= '0;
            ram_rd_addr     <= '0;
            wr_ack          <= 1'b0;
            rd_ack          <= 1'b0;
            wr_done         <= 1'b0;
            rd_done         <= 1'b0;
        end else begin
            wr_ack  <= 1'b0;
            rd_ack  <= 1'b0;
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_wr) begin
                        r_state         <= c_WR_BURST;
                        ram_wr_en       <= 1'b1;
                        ram_wr_addr     <= wr_addr & c_ALIGN_MASK;
                        r_len           <= wr_len;
                        r_beat_cnt      <= '0;
                        r_last_grant_rd <= 1'b0;
                        wr_ack          <= 1'b1;
                    end else if (w_grant_rd) begin
                        r_state         <= c_RD_BURST;
                        ram_rd_en       <= 1'b1;
                        ram_rd_addr     <= rd_addr & c_ALIGN_MASK;
                        r_len           <= rd_len;
                        r_beat_cnt      <= '0;
                        r_last_grant_rd <= 1'b1;
                        rd_ack          <= 1'b1;
                    end
                end
                c_WR_BURST: begin
                    r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                    if (r_beat_cnt == r_len) begin
                        r_state   <= c_IDLE;
                        ram_wr_en <= 1'b0;
                        wr_done   <= 1'b1;
                    end
                end
                c_RD_BURST: begin
                    r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                    if (r_beat_cnt == r_len) begin
                        r_state   <= c_IDLE;
                        ram_rd_en <= 1'b0;
                        rd_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    ram_wr_en <= 1'b0;
                    ram_rd_en <= 1'b0;
                end
            endcase
        end
    end

    // Returning to IDLE after each burst guarantees the low-enable gap the RAM needs.
    assign busy        = (r_state != c_IDLE);
    assign ram_data    = ram_wr_en ? wr_data : {64{1'bz}};
    assign wr_data_pop = ram_wr_en;
    assign rd_data     = ram_data;
    assign rd_data_vld = ram_rd_en;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_burst_arbiter
// Brief    : Self-checking bench; burst RAM model plus cycle-timeline reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req, rd_req;
    logic [29:0] wr_addr, rd_addr;
    logic [7:0]  wr_len, rd_len;
    logic [63:0] wr_data;
    logic        wr_ack, wr_data_pop, wr_done;
    logic        rd_ack, rd_data_vld, rd_done;
    logic [63:0] rd_data;
    logic        busy, ram_wr_en, ram_rd_en;
    logic [29:0] ram_wr_addr, ram_rd_addr;
    wire  [63:0] ram_data;

    ram_burst_arbiter #(.ADDR_W(30), .LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
        .wr_data(wr_data), .wr_data_pop(wr_data_pop), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_data_vld(rd_data_vld), .rd_done(rd_done),
        .busy(busy), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // Burst RAM: internal beat counter restarts whenever both enables are low.
    logic [63:0] ram_mem [0:255];
    logic [63:0] ref_mem [0:255];
    logic [63:0] wbuf    [0:255];
    logic [7:0]  ram_k, wr_k, rd_idx;
    logic        mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
        end else if (ram_wr_en) begin
            ram_mem[8'(ram_wr_addr[10:3] + ram_k)] <= ram_data;
        end
        ram_k <= (ram_wr_en || ram_rd_en) ? ram_k + 8'd1 : 8'd0;
        wr_k  <= wr_data_pop ? wr_k + 8'd1 : 8'd0;
    end

    assign rd_idx   = ram_rd_addr[10:3] + ram_k;
    assign ram_data = ram_rd_en ? ram_mem[rd_idx] : 64'bz;
    assign wr_data  = wbuf[wr_k];

    int n_checks = 0;
    int n_errors = 0;
    bit m_last_rd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] flags();
        return {ram_wr_en, ram_rd_en, wr_ack, rd_ack, wr_done, rd_done, busy, wr_data_pop, rd_data_vld};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drop_acked();
        if (wr_ack) begin wr_req = 1'b0; wr_addr = 30'($urandom); wr_len = 8'($urandom); end
        if (rd_ack) begin rd_req = 1'b0; rd_addr = 30'($urandom); rd_len = 8'($urandom); end
    endtask

    // Expected timeline: grant 1 cycle after request, len+1 beats, done next cycle,
    // the losing request granted in that done/IDLE cycle.
    task automatic do_pair(input bit dw, input logic [29:0] wa, input int wl,
                           input bit dr, input logic [29:0] ra, input int rl);
        int ws, we, rs, re, tend;
        bit wr_first, in_w, in_r;
        logic [8:0] exp_f;
        logic [7:0] idx;
        wr_first = dw && (!dr || m_last_rd);
        ws = -10; we = -10; rs = -10; re = -10;
        if (wr_first) begin
            ws = 1; we = wl + 1;
            if (dr) begin rs = we + 2; re = rs + rl; end
        end else begin
            rs = 1; re = rl + 1;
            if (dw) begin ws = re + 2; we = ws + wl; end
        end
        tend = (we > re) ? we + 1 : re + 1;
        m_last_rd = (dw && dr) ? wr_first : dr;
        for (int k = 0; k <= wl; k++) wbuf[k] = {$urandom, $urandom};
        wr_req = dw; wr_addr = wa; wr_len = wl[7:0];
        rd_req = dr; rd_addr = ra; rd_len = rl[7:0];
        for (int t = 1; t <= tend; t++) begin
            step();
            in_w  = dw && (t >= ws) && (t <= we);
            in_r  = dr && (t >= rs) && (t <= re);
            exp_f = {in_w, in_r, t == ws, t == rs, t == we + 1, t == re + 1, in_w || in_r, in_w, in_r};
            check_eq("flags", 64'(flags()), 64'(exp_f));
            if (in_w) begin
                check_eq("ram_wr_addr", 64'(ram_wr_addr), 64'(wa & ~30'h7));
                check_eq("wr_bus", ram_data, wbuf[t - ws]);
                idx = wa[10:3] + 8'(t - ws);
                ref_mem[idx] = wbuf[t - ws];
            end
            if (in_r) begin
                check_eq("ram_rd_addr", 64'(ram_rd_addr), 64'(ra & ~30'h7));
                idx = ra[10:3] + 8'(t - rs);
                check_eq("rd_data", rd_data, ref_mem[idx]);
            end
            drop_acked();
        end
    endtask

    // 8-beat read abandoned by reset during its third beat.
    task automatic do_abort();
        rd_req = 1'b1; rd_addr = 30'h100; rd_len = 8'd7;
        for (int t = 1; t <= 3; t++) begin
            step();
            check_eq("abort_rd_en", 64'(ram_rd_en), 64'd1);
            drop_acked();
        end
        rst = 1'b1;
        step();
        check_eq("abort_flags", 64'(flags()), 64'd0);
        rst = 1'b0;
        m_last_rd = 1'b1;
        step();
        check_eq("abort_no_done", 64'(flags()), 64'd0);
    endtask

    initial begin
        bit [1:0] sel;
        int wl, rl;
        rst = 1'b1; mem_clr = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
        for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; wbuf[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_flags", 64'(flags()), 64'd0);
        check_eq("rst_addrs", {4'd0, ram_wr_addr, ram_rd_addr}, 64'd0);
        rst = 1'b0; mem_clr = 1'b0; m_last_rd = 1'b1;
        step();

        do_pair(1'b1, 30'h80,  2, 1'b1, 30'h80, 2);   // contention after reset: write wins
        do_pair(1'b1, 30'h40,  3, 1'b0, 30'h0,  0);
        do_pair(1'b1, 30'h300, 1, 1'b1, 30'h40, 3);   // last grant was write: read wins
        do_pair(1'b0, 30'h0,   0, 1'b1, 30'h40, 3);
        do_pair(1'b1, 30'h08,  0, 1'b0, 30'h0,  0);
        do_pair(1'b1, 30'h45,  2, 1'b0, 30'h0,  0);
        do_pair(1'b0, 30'h0,   0, 1'b1, 30'h47, 2);
        do_abort();
        do_pair(1'b0, 30'h0,   0, 1'b1, 30'h40, 3);

        for (int n = 0; n < 40; n++) begin
            sel = 2'($urandom_range(1, 3));
            wl  = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 15));
            rl  = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 15));
            do_pair(sel[0], 30'($urandom), wl, sel[1], 30'($urandom), rl);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
